// File: rtl/imem_streamer.sv
// imem_streamer: loads a program into a 256x15 store, then streams address/word pairs one per cycle.
// Optional build macro IMEM_STREAM_LOOP_EN: when defined, the last word wraps back to word 0 instead of halting.
module imem_streamer (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        load_valid_i,
  input  logic [14:0] load_data_i,
  input  logic        load_last_i,
  output logic        load_ready_o,
  input  logic        start_i,
  input  logic        stop_i,
  output logic [7:0]  address_imem_o,
  output logic [14:0] q_imem_o,
  output logic        insn_valid_o,
  output logic [1:0]  state_o,
  output logic [8:0]  prog_len_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, HALT = 2'd3} state_e;
  state_e      state_q, state_d;
  logic [7:0]  wptr_q, wptr_d, addr_q, addr_d;
  logic [14:0] q_q, q_d;
  logic        valid_q, valid_d;
  logic [8:0]  len_q, len_d;
  logic [14:0] mem [256];
  logic        xfer, load_end, at_end;
  logic [7:0]  waddr;

  assign load_ready_o   = reset_ni && (state_q == IDLE || state_q == LOAD);
  assign xfer           = load_valid_i && load_ready_o;
  assign waddr          = (state_q == IDLE) ? 8'd0 : wptr_q;
  assign load_end       = load_last_i || waddr == 8'd255;
  assign at_end         = ({1'b0, addr_q} + 9'd1) == len_q;
  assign address_imem_o = addr_q;
  assign q_imem_o       = q_q;
  assign insn_valid_o   = valid_q;
  assign state_o        = state_q;
  assign prog_len_o     = len_q;

  // Program store: written only by accepted load transfers, never reset.
  always_ff @(posedge clock_i)
    if (xfer) mem[waddr] <= load_data_i;

  // Next-state and registered output pair; a transfer in IDLE takes precedence over start.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    addr_d  = addr_q;
    q_d     = q_q;
    valid_d = valid_q;
    len_d   = len_q;
    case (state_q)
      IDLE:
        if (xfer) begin
          wptr_d  = 8'd1;
          len_d   = load_last_i ? 9'd1 : 9'd0;
          state_d = load_last_i ? IDLE : LOAD;
        end else if (start_i && len_q != 9'd0) begin
          state_d = RUN;
          addr_d  = 8'd0;
          q_d     = mem[0];
          valid_d = 1'b1;
        end
      LOAD:
        if (xfer) begin
          wptr_d = load_end ? wptr_q : wptr_q + 8'd1;
          if (load_end) begin
            len_d   = {1'b0, wptr_q} + 9'd1;
            state_d = IDLE;
          end
        end
      RUN:
        if (stop_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          q_d     = 15'd0;
        end else if (!at_end) begin
          addr_d = addr_q + 8'd1;
          q_d    = mem[addr_q + 8'd1];
        end else begin
`ifdef IMEM_STREAM_LOOP_EN
          addr_d = 8'd0;
          q_d    = mem[0];
`else
          state_d = HALT;
          valid_d = 1'b0;
          q_d     = 15'd0;
`endif
        end
      HALT:
        if (stop_i) state_d = IDLE;
        else if (start_i) begin
          state_d = RUN;
          addr_d  = 8'd0;
          q_d     = mem[0];
          valid_d = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) begin
      state_q <= IDLE;
      wptr_q  <= 8'd0;
      addr_q  <= 8'd0;
      q_q     <= 15'd0;
      valid_q <= 1'b0;
      len_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      addr_q  <= addr_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      len_q   <= len_d;
    end
endmodule

// File: tb/tb_imem_streamer.sv
// tb_imem_streamer: randomized load/stream checks of imem_streamer against a transaction-level program model.
module tb_imem_streamer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        load_valid = 1'b0, load_last = 1'b0, start = 1'b0, stop = 1'b0;
  logic [14:0] load_data = 15'd0;
  logic        load_ready, insn_valid;
  logic [7:0]  address_imem;
  logic [14:0] q_imem;
  logic [1:0]  state;
  logic [8:0]  prog_len;
  int          vectors = 0, miscompares = 0;
  logic [14:0] ref_mem [256];
  int          ref_len = 0;

  imem_streamer dut (
    .clock_i(clk), .reset_ni(rst_n), .load_valid_i(load_valid), .load_data_i(load_data),
    .load_last_i(load_last), .load_ready_o(load_ready), .start_i(start), .stop_i(stop),
    .address_imem_o(address_imem), .q_imem_o(q_imem), .insn_valid_o(insn_valid),
    .state_o(state), .prog_len_o(prog_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input logic [14:0] words[$], input bit with_last);
    for (int i = 0; i < words.size(); i++) begin
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = with_last && i == words.size() - 1;
      check("ld_ready", 32'(load_ready), 32'd1);
      ref_mem[i] = words[i];
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    ref_len    = words.size();
    check("ld_len", 32'(prog_len), 32'(ref_len));
    check("ld_state", 32'(state), 32'd0);
    check("ld_ready_end", 32'(load_ready), 32'd1);
  endtask

  task automatic run_prog(input bit junk);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < ref_len; i++) begin
      if (i > 0) tick();
      if (junk) begin
        load_valid = 1'b1;
        load_data  = 15'($urandom);
        check("run_ready", 32'(load_ready), 32'd0);
      end
      check("run_state", 32'(state), 32'd2);
      check("run_addr", 32'(address_imem), 32'(i));
      check("run_q", 32'(q_imem), 32'(ref_mem[i]));
      check("run_valid", 32'(insn_valid), 32'd1);
    end
    tick();
`ifdef IMEM_STREAM_LOOP_EN
    check("wrap_state", 32'(state), 32'd2);
    check("wrap_addr", 32'(address_imem), 32'd0);
    check("wrap_q", 32'(q_imem), 32'(ref_mem[0]));
    check("wrap_valid", 32'(insn_valid), 32'd1);
    if (ref_len > 1) begin
      tick();
      check("wrap_addr1", 32'(address_imem), 32'd1);
      check("wrap_q1", 32'(q_imem), 32'(ref_mem[1]));
      check("wrap_valid1", 32'(insn_valid), 32'd1);
    end
    load_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_state", 32'(state), 32'd0);
    check("stop_valid", 32'(insn_valid), 32'd0);
    check("stop_q", 32'(q_imem), 32'd0);
`else
    check("halt_state", 32'(state), 32'd3);
    check("halt_valid", 32'(insn_valid), 32'd0);
    check("halt_q", 32'(q_imem), 32'd0);
    check("halt_addr", 32'(address_imem), 32'(ref_len - 1));
    check("halt_ready", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_state", 32'(state), 32'd2);
    check("restart_addr", 32'(address_imem), 32'd0);
    check("restart_q", 32'(q_imem), 32'(ref_mem[0]));
    check("restart_valid", 32'(insn_valid), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_state", 32'(state), 32'd0);
    check("stop_valid", 32'(insn_valid), 32'd0);
    check("stop_q", 32'(q_imem), 32'd0);
    check("stop_addr", 32'(address_imem), 32'd0);
`endif
    check("run_len_kept", 32'(prog_len), 32'(ref_len));
  endtask

  initial begin
    logic [14:0] words[$];
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_addr", 32'(address_imem), 32'd0);
    check("rst_q", 32'(q_imem), 32'd0);
    check("rst_valid", 32'(insn_valid), 32'd0);
    check("rst_len", 32'(prog_len), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_empty", 32'(state), 32'd0);
    words = '{15'h1001, 15'h2002, 15'h3003};
    load_prog(words, 1'b1);
    run_prog(1'b0);
    words = '{};
    for (int i = 0; i < 256; i++) words.push_back(15'($urandom));
    load_prog(words, 1'b0);
    run_prog(1'b0);
    words = '{15'($urandom)};
    load_prog(words, 1'b1);
    run_prog(1'b0);
    words = '{15'($urandom), 15'($urandom)};
    load_prog(words, 1'b1);
    run_prog(1'b1);
    run_prog(1'b0);
    words = '{15'($urandom), 15'($urandom), 15'($urandom), 15'($urandom)};
    load_prog(words, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("both_pre_addr", 32'(address_imem), 32'd1);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("both_state", 32'(state), 32'd0);
    check("both_valid", 32'(insn_valid), 32'd0);
    check("both_addr", 32'(address_imem), 32'd1);
    check("both_q", 32'(q_imem), 32'd0);
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = 15'($urandom);
      ref_mem[i] = load_data;
      tick();
    end
    load_valid = 1'b0;
    check("midload_state", 32'(state), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    ref_len = 0;
    check("async_state", 32'(state), 32'd0);
    check("async_len", 32'(prog_len), 32'd0);
    check("async_ready", 32'(load_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_after_rst", 32'(state), 32'd0);
    check("start_after_rst_v", 32'(insn_valid), 32'd0);
    repeat (6) begin
      words = '{};
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) words.push_back(15'($urandom));
      load_prog(words, 1'b1);
      run_prog(1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_streamer.md
IMEM_STREAMER -- requirements
Module: imem_streamer

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low (asserted at 0) reset.
REQ-003 SHALL have port: load_valid  in  1  program-load word offered.
REQ-004 SHALL have port: load_data  in  15  program word.
REQ-005 SHALL have port: load_last  in  1  marks final word of program.
REQ-006 SHALL have port: load_ready  out  1  load word accepted when high with load_valid.
REQ-007 SHALL have port: start  in  1  begin streaming from address 0.
REQ-008 SHALL have port: stop  in  1  abort streaming, return to IDLE.
REQ-009 SHALL have port: address_imem  out  8  address of current instruction word.
REQ-010 SHALL have port: q_imem  out  15  instruction word at address_imem.
REQ-011 SHALL have port: insn_valid  out  1  address_imem/q_imem pair is a live instruction.
REQ-012 SHALL have port: state  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3.
REQ-013 SHALL have port: prog_len  out  9  loaded program length, 0..256.

Function
REQ-014 SHALL hold a 256 x 15 program store; contents not reset.
REQ-015 SHALL drive load_ready=1 in IDLE and LOAD, 0 in RUN and HALT; a transfer is load_valid & load_ready at a rising edge.
REQ-016 SHALL, on a transfer in IDLE, write load_data to word 0, clear prog_len to 0, and enter LOAD (or stay IDLE with prog_len=1 if load_last).
REQ-017 SHALL, on each LOAD transfer, write word at write pointer and increment it; with load_last, set prog_len=pointer+1 and enter IDLE.
REQ-018 SHALL treat a transfer writing word 255 as last regardless of load_last: prog_len=256, enter IDLE; no wrap of write pointer.
REQ-019 SHALL ignore start in LOAD, and ignore start in IDLE when prog_len=0.
REQ-020 SHALL, on start in IDLE or HALT, enter RUN and on the same edge register address_imem=0, q_imem=word 0, insn_valid=1.
REQ-021 SHALL, each RUN cycle with address_imem < prog_len-1, advance to address_imem+1 with q_imem=word at that address on the same edge (pair always consistent, one instruction per cycle).
REQ-022 SHALL, in RUN with address_imem = prog_len-1, at next edge enter HALT: insn_valid=0, q_imem=0, address_imem held (loop behaviour per REQ-030).
REQ-023 SHALL, on stop in RUN or HALT, enter IDLE next edge with insn_valid=0, q_imem=0, address_imem held.
REQ-024 SHALL give stop priority over start when both high; stop in IDLE/LOAD ignored.
REQ-025 SHALL drive outputs only on rising edges so they are stable at the falling edge on which the downstream pipeline latches.
REQ-026 SHALL ignore load_valid and load_data in RUN and HALT.

Reset
REQ-027 SHALL, while reset=0, asynchronously force state=IDLE, address_imem=0, q_imem=0, insn_valid=0, prog_len=0, write pointer=0.
REQ-028 SHALL abandon any in-progress load or run on reset; program store retained but prog_len=0 forces reload before start.
REQ-029 SHALL accept no transfer while reset=0.

Configuration
REQ-030 SHALL honour macro IMEM_STREAM_LOOP_EN: defined -- at address_imem=prog_len-1 in RUN, next edge presents address 0/word 0 with insn_valid=1 and stays in RUN until stop; undefined -- enters HALT per REQ-022 and HALT state is reachable.

Verification
REQ-031 SHALL test: load 3 words 0x1001,0x2002,0x3003 (last on third), start -> prog_len=3, then address/q = 0/0x1001, 1/0x2002, 2/0x3003 with insn_valid=1, then HALT, insn_valid=0, q_imem=0.
REQ-032 SHALL test: load 256 words without load_last -> after word 255 state=IDLE, prog_len=256, load_ready=1; start streams 0..255 then HALT.
REQ-033 SHALL test: start and stop high together in RUN at address 1 -> IDLE next edge, insn_valid=0, address_imem=1.
REQ-034 SHALL test: reset pulsed low mid-load after 2 words -> immediate IDLE, prog_len=0; start then ignored (state stays 0).
REQ-035 SHALL test: with IMEM_STREAM_LOOP_EN defined, 2-word program -> addresses 0,1,0,1,... with insn_valid=1 until stop.
REQ-036 SHALL test: load_valid held high during RUN -> load_ready=0, program store and prog_len unchanged.
